// File: rtl/alu.sv
// 16-bit registered ALU for the execute stage: rotates, shifts, add-with-carry
// and bitwise logic with optional operand inversion; result and flags after one clock.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    input  logic [2:0]  op,
    input  logic        invA,
    input  logic        invB,
    input  logic        sign,
    output logic [15:0] out,
    output logic        ofl,
    output logic        zero
);

    typedef enum logic [2:0] {
        OP_ROL = 3'd0,
        OP_SLL = 3'd1,
        OP_ROR = 3'd2,
        OP_SRA = 3'd3,
        OP_ADD = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_AND = 3'd7
    } op_e;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [3:0]  w_n;
    logic [4:0]  w_n_inv;
    logic [16:0] w_sum;
    logic [15:0] w_rol;
    logic [15:0] w_ror;
    logic [15:0] w_sra;
    logic [15:0] w_res;
    logic        w_ofl;

    logic [15:0] r_out;
    logic        r_ofl;

    assign w_a     = invA ? ~a : a;
    assign w_b     = invB ? ~b : b;
    assign w_n     = w_b[3:0];
    assign w_n_inv = 5'd16 - {1'b0, w_n};

    // A shift by 16 of a 16-bit value yields 0, so n = 0 passes A' unchanged.
    assign w_rol = (w_a << w_n) | (w_a >> w_n_inv);
    assign w_ror = (w_a >> w_n) | (w_a << w_n_inv);
    assign w_sra = $unsigned($signed(w_a) >>> w_n);
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {16'd0, cin};

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_res = w_a;
        w_ofl = 1'b0;
        case (op_e'(op))
            OP_ROL: w_res = w_rol;
            OP_SLL: w_res = w_a << w_n;
            OP_ROR: w_res = w_ror;
            OP_SRA: w_res = w_sra;
            OP_ADD: begin
                w_res = w_sum[15:0];
                if (sign) w_ofl = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
                else      w_ofl = w_sum[16];
            end
            OP_OR:  w_res = w_a | w_b;
            OP_XOR: w_res = w_a ^ w_b;
            OP_AND: w_res = w_a & w_b;
            default: w_res = w_a;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= 16'h0000;
            r_ofl <= 1'b0;
        end else begin
            r_out <= w_res;
            r_ofl <= w_ofl;
        end
    end

    assign out  = r_out;
    assign ofl  = r_ofl;
    assign zero = (r_out == 16'h0000);

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: a driver pushes model results into a queue and a
// monitor pops and compares them one clock after each issue.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        cin = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        invA = 1'b0;
    logic        invB = 1'b0;
    logic        sign = 1'b0;
    logic [15:0] out;
    logic        ofl;
    logic        zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] out;
        logic        ofl;
        logic        zero;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    alu dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .op(op),
        .invA(invA), .invB(invB), .sign(sign),
        .out(out), .ofl(ofl), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act_out, input logic act_ofl,
                         input logic act_zero, input logic [15:0] exp_out, input logic exp_ofl,
                         input logic exp_zero);
        checks++;
        if (act_out !== exp_out || act_ofl !== exp_ofl || act_zero !== exp_zero) begin
            errors++;
            $display("FAIL %s: got out=%h ofl=%b zero=%b, expected out=%h ofl=%b zero=%b",
                     name, act_out, act_ofl, act_zero, exp_out, exp_ofl, exp_zero);
        end
    endtask

    // Reference model written from the arithmetic rules, not the gate structure.
    function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                                   input logic [2:0] iop, input logic iia, input logic iib,
                                   input logic isg, input string name);
        exp_t e;
        logic [15:0] x;
        logic [15:0] y;
        int n, ux, uy, us, sx, sy, ss;
        x = iia ? ~ia : ia;
        y = iib ? ~ib : ib;
        n = int'(y[3:0]);
        e.ofl = 1'b0;
        e.name = name;
        case (iop)
            3'd0: for (int i = 0; i < n; i++) x = {x[14:0], x[15]};
            3'd1: for (int i = 0; i < n; i++) x = {x[14:0], 1'b0};
            3'd2: for (int i = 0; i < n; i++) x = {x[0], x[15:1]};
            3'd3: for (int i = 0; i < n; i++) x = {x[15], x[15:1]};
            3'd4: begin
                ux = int'(x); uy = int'(y);
                us = ux + uy + int'(ic);
                sx = x[15] ? ux - 65536 : ux;
                sy = y[15] ? uy - 65536 : uy;
                ss = sx + sy + int'(ic);
                e.ofl = isg ? (ss > 32767 || ss < -32768) : (us > 65535);
                x = us[15:0];
            end
            3'd5: x = x | y;
            3'd6: x = x ^ y;
            default: x = x & y;
        endcase
        e.out = x;
        e.zero = (x == 16'h0);
        return e;
    endfunction

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                         input logic [2:0] iop, input logic iia, input logic iib,
                         input logic isg, input string name);
        @(negedge clk);
        rst_n = 1'b1;
        a = ia; b = ib; cin = ic; op = iop; invA = iia; invB = iib; sign = isg;
        sb_q.push_back(model(ia, ib, ic, iop, iia, iib, isg, name));
    endtask

    task automatic reset_cycle(input string name);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        a = 16'hFFFF; b = 16'h0001; op = 3'd4; cin = 1'b1;
        e.out = 16'h0; e.ofl = 1'b0; e.zero = 1'b1; e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: one result per clock, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, out, ofl, zero, e.out, e.ofl, e.zero);
            end
        end
    end

    initial begin
        int budget;
        reset_cycle("reset0");
        reset_cycle("reset1");

        issue(16'h00EA, 16'd4,  0, 3'd0, 0, 0, 0, "rol4");
        issue(16'h00EA, 16'd4,  0, 3'd2, 0, 0, 0, "ror4");
        issue(16'h00EA, 16'd4,  0, 3'd1, 0, 0, 0, "sll4");
        issue(16'hFA7B, 16'd4,  0, 3'd3, 0, 0, 0, "sra4");
        issue(16'h0018, 16'd12, 0, 3'd1, 0, 0, 0, "sll12");
        issue(16'h1234, 16'h0010, 1, 3'd0, 0, 0, 0, "rol_n0");
        issue(16'h8001, 16'h0000, 0, 3'd3, 0, 0, 0, "sra_n0");
        issue(16'h8001, 16'h000F, 0, 3'd2, 0, 0, 0, "ror15");
        issue(16'h0163, 16'h007B, 0, 3'd4, 0, 0, 0, "add_c0");
        issue(16'h0163, 16'h007B, 1, 3'd4, 0, 0, 0, "add_c1");
        issue(16'hFFFF, 16'h0001, 0, 3'd4, 0, 0, 0, "add_wrap");
        issue(16'h0123, 16'h0234, 1, 3'd5, 0, 0, 0, "or");
        issue(16'h0123, 16'h0234, 1, 3'd6, 0, 0, 0, "xor");
        issue(16'h0123, 16'h0234, 1, 3'd7, 0, 0, 0, "and");
        issue(16'h0123, 16'h0234, 0, 3'd4, 1, 0, 0, "add_invA");
        issue(16'h0123, 16'h0234, 0, 3'd4, 1, 1, 0, "add_invAB");
        issue(16'h0123, 16'h0234, 0, 3'd4, 0, 1, 0, "add_invB");
        issue(16'd20000, 16'd20000, 0, 3'd4, 0, 0, 1, "sofl_pos");
        issue(16'hB1E0, 16'hB1E0, 0, 3'd4, 0, 0, 1, "sofl_neg");
        issue(16'd10, 16'd20, 0, 3'd4, 0, 0, 1, "sofl_none");
        issue(16'hFFF6, 16'hB1E0, 0, 3'd4, 0, 0, 1, "sofl_negok");
        issue(16'd60000, 16'd60000, 0, 3'd4, 0, 0, 0, "uofl_set");
        issue(16'd30000, 16'd30000, 0, 3'd4, 0, 0, 0, "uofl_clr");
        issue(16'hFFFF, 16'hFFFF, 1, 3'd5, 0, 0, 0, "ofl_nonadd");
        reset_cycle("reset_mid");
        issue(16'h0001, 16'h0001, 0, 3'd4, 0, 0, 0, "after_reset");

        for (int i = 0; i < 300; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
